// File: rtl/alu_cmd_sequencer_if.sv
// Bundle between the ALU command sequencer, its operand producer and the ALU.
// The master side feeds operands and control; the slave side is the sequencer.
interface alu_cmd_sequencer_if #(
   parameter int N     = 16,
   parameter int DEPTH = 8
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic          push_valid;
   logic          push_ready;
   logic [4:0]    push_cmd;
   logic [N-1:0]  push_a;
   logic [N-1:0]  push_b;
   logic          start;
   logic          halt_on_err;
   logic          alu_err;
   logic [N-1:0]  A;
   logic [N-1:0]  B;
   logic [4:0]    CMD;
   logic          alu_rst;
   logic          noOp;
   logic          busy;
   logic          done;
   logic          aborted;
   logic [7:0]    err_count;
   logic [LW-1:0] level;

   modport master (
      output push_valid, push_cmd, push_a, push_b, start, halt_on_err, alu_err,
      input  push_ready, A, B, CMD, alu_rst, noOp, busy, done, aborted, err_count, level
   );

   modport slave (
      input  push_valid, push_cmd, push_a, push_b, start, halt_on_err, alu_err,
      output push_ready, A, B, CMD, alu_rst, noOp, busy, done, aborted, err_count, level
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers (CMD, A, B) triples and, on start, clears the ALU and issues one
// buffered operation per clock, counting ALU errors and optionally aborting.
module alu_cmd_sequencer #(
   parameter int N     = 16,
   parameter int DEPTH = 8,
   parameter int DRAIN = 2
) (
   input  logic CLK,
   input  logic RST,
   alu_cmd_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
   localparam logic [CW-1:0] DRAIN_LOAD = CW'((DRAIN > 0) ? DRAIN - 1 : 0);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2*N+4:0] mem [DEPTH];
   logic [AW:0]    wptr_reg, rptr_reg;
   logic [2:0]     state_reg, state_next;
   logic [N-1:0]   a_reg, a_next, b_reg, b_next;
   logic [4:0]     cmd_reg, cmd_next;
   logic           alu_rst_reg, alu_rst_next;
   logic           noop_reg, noop_next;
   logic           busy_reg, busy_next;
   logic           done_reg, done_next;
   logic           aborted_reg, aborted_next;
   logic [7:0]     err_reg, err_next;
   logic [CW-1:0]  cnt_reg, cnt_next;
   logic           empty, full, push_fire, pop, flush, halt;
   logic [2*N+4:0] head;

   assign empty     = (wptr_reg == rptr_reg);
   assign full      = (wptr_reg[AW] != rptr_reg[AW]) && (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
   assign push_fire = bus.push_valid && !full;
   assign head      = mem[rptr_reg[AW-1:0]];

   always_ff @(posedge CLK) begin
      if (push_fire) mem[wptr_reg[AW-1:0]] <= {bus.push_cmd, bus.push_a, bus.push_b};
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wptr_reg <= '0;
         rptr_reg <= '0;
      end else begin
         if (push_fire) wptr_reg <= wptr_reg + (AW+1)'(1);
         if (flush)     rptr_reg <= wptr_reg;
         else if (pop)  rptr_reg <= rptr_reg + (AW+1)'(1);
      end
   end

   // Outputs are computed for the state being entered, so the first pop lands
   // on the edge leaving CLEAR and each following RUN edge pops the next head.
   always_comb begin
      state_next   = state_reg;
      a_next       = a_reg;
      b_next       = b_reg;
      cmd_next     = cmd_reg;
      alu_rst_next = 1'b0;
      noop_next    = 1'b1;
      done_next    = 1'b0;
      aborted_next = aborted_reg;
      err_next     = err_reg;
      cnt_next     = cnt_reg;
      pop          = 1'b0;
      flush        = 1'b0;
      halt         = 1'b0;
      if ((state_reg == S_RUN || state_reg == S_DRAIN) && bus.alu_err) begin
         if (err_reg != 8'hFF) err_next = err_reg + 8'd1;
         halt = bus.halt_on_err;
      end
      case (state_reg)
         S_IDLE: begin
            if (bus.start) begin
               state_next   = S_CLEAR;
               alu_rst_next = 1'b1;
               noop_next    = 1'b0;
               a_next       = '0;
               b_next       = '0;
               cmd_next     = '0;
               err_next     = '0;
               aborted_next = 1'b0;
            end
         end
         S_CLEAR, S_RUN: begin
            if (halt) begin
               flush        = 1'b1;
               aborted_next = 1'b1;
               done_next    = 1'b1;
               state_next   = S_DONE;
            end else if (state_reg == S_RUN && noop_reg) begin
               // The empty RUN cycle just shown ends the batch.
               if (DRAIN == 0) begin
                  state_next = S_DONE;
                  done_next  = 1'b1;
               end else begin
                  state_next = S_DRAIN;
                  cnt_next   = DRAIN_LOAD;
               end
            end else begin
               state_next = S_RUN;
               if (!empty) begin
                  pop                        = 1'b1;
                  {cmd_next, a_next, b_next} = head;
                  noop_next                  = 1'b0;
               end
            end
         end
         S_DRAIN: begin
            if (halt) begin
               flush        = 1'b1;
               aborted_next = 1'b1;
               done_next    = 1'b1;
               state_next   = S_DONE;
            end else if (cnt_reg == '0) begin
               done_next  = 1'b1;
               state_next = S_DONE;
            end else begin
               cnt_next = cnt_reg - CW'(1);
            end
         end
         default: state_next = S_IDLE;
      endcase
      busy_next = (state_next != S_IDLE);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg   <= S_IDLE;
         a_reg       <= '0;
         b_reg       <= '0;
         cmd_reg     <= '0;
         alu_rst_reg <= 1'b0;
         noop_reg    <= 1'b1;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         aborted_reg <= 1'b0;
         err_reg     <= '0;
         cnt_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         a_reg       <= a_next;
         b_reg       <= b_next;
         cmd_reg     <= cmd_next;
         alu_rst_reg <= alu_rst_next;
         noop_reg    <= noop_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         aborted_reg <= aborted_next;
         err_reg     <= err_next;
         cnt_reg     <= cnt_next;
      end
   end

   assign bus.push_ready = !full;
   assign bus.level      = wptr_reg - rptr_reg;
   assign bus.A          = a_reg;
   assign bus.B          = b_reg;
   assign bus.CMD        = cmd_reg;
   assign bus.alu_rst    = alu_rst_reg;
   assign bus.noOp       = noop_reg;
   assign bus.busy       = busy_reg;
   assign bus.done       = done_reg;
   assign bus.aborted    = aborted_reg;
   assign bus.err_count  = err_reg;
endmodule
